// File: rtl/riscv_unified_mem_sequencer_if.sv
// Shared single-ported memory bus between the multi-cycle sequencer (master)
// and a variable-latency memory (slave).
interface riscv_unified_mem_sequencer_if;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memReady;

    modport master (
        output memReq, memWe, memAddr, memWdata,
        input  memRdata, memReady
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata,
        output memRdata, memReady
    );
endinterface

// File: rtl/riscv_unified_mem_sequencer.sv
// Multi-cycle fetch/data sequencer that runs the RISC-V datapath against one
// shared variable-latency memory and emits a one-cycle commit per instruction.
module riscv_unified_mem_sequencer (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [31:0]                           pc,
    input  logic [31:0]                           aluOut,
    input  logic [31:0]                           rs2,
    input  logic                                  memoryReadEnable,
    input  logic                                  memoryWriteEnable,
    output logic [31:0]                           instruction,
    output logic [31:0]                           memoryOut,
    output logic                                  commit,
    output logic                                  misaligned,
    output logic [31:0]                           retired,
    riscv_unified_mem_sequencer_if.master         mem
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_DATA      = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instruction;
    logic [31:0] r_memoryOut;
    logic        r_misaligned;
    logic [31:0] r_retired;

    logic        w_req;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_commit;
    logic        w_memEn;
    logic        w_aligned;
    logic        w_xfer;

    assign w_memEn   = memoryReadEnable | memoryWriteEnable;
    assign w_aligned = (aluOut[1:0] == 2'b00);
    assign w_xfer    = w_req & mem.memReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     if (w_xfer) w_next = S_DECODE;
            S_DECODE: begin
                if (!w_memEn)       w_next = S_FETCH;
                else if (w_aligned) w_next = S_DATA;
                else                w_next = S_WRITEBACK;
            end
            S_DATA:      if (w_xfer) w_next = S_WRITEBACK;
            S_WRITEBACK: w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    // Everything on the bus is forced quiet while rst is high, so a request
    // is withdrawn asynchronously even though the state register sits in FETCH.
    always_comb begin
        w_req    = 1'b0;
        w_we     = 1'b0;
        w_addr   = 32'h0;
        w_wdata  = 32'h0;
        w_commit = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    w_req  = 1'b1;
                    w_addr = pc;
                end
                S_DECODE: begin
                    w_commit = ~w_memEn;
                end
                S_DATA: begin
                    w_req   = 1'b1;
                    w_we    = memoryWriteEnable;
                    w_addr  = aluOut;
                    w_wdata = rs2;
                end
                S_WRITEBACK: begin
                    w_commit = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instruction <= 32'h0000_0013;
            r_memoryOut   <= 32'h0;
            r_misaligned  <= 1'b0;
            r_retired     <= 32'h0;
        end else begin
            if (r_state == S_FETCH && w_xfer) begin
                r_instruction <= mem.memRdata;
            end
            if (r_state == S_DECODE && w_memEn && !w_aligned) begin
                r_memoryOut  <= 32'h0;
                r_misaligned <= 1'b1;
            end
            // A store wins over a simultaneous load, leaving the load register untouched.
            if (r_state == S_DATA && w_xfer && !memoryWriteEnable) begin
                r_memoryOut <= mem.memRdata;
            end
            if (w_commit) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign mem.memReq   = w_req;
    assign mem.memWe    = w_we;
    assign mem.memAddr  = w_addr;
    assign mem.memWdata = w_wdata;
    assign instruction  = r_instruction;
    assign memoryOut    = r_memoryOut;
    assign commit       = w_commit;
    assign misaligned   = r_misaligned;
    assign retired      = r_retired;

endmodule

// File: tb/tb_riscv_unified_mem_sequencer.sv
// Directed bench for riscv_unified_mem_sequencer: the bench plays both the
// datapath (pc/aluOut/rs2/decoder enables) and the memory (memRdata/memReady).
module tb_riscv_unified_mem_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] aluOut;
    logic [31:0] rs2;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic [31:0] instruction;
    logic [31:0] memoryOut;
    logic        commit;
    logic        misaligned;
    logic [31:0] retired;

    int n_cmp;
    int n_fail;

    riscv_unified_mem_sequencer_if bus ();

    riscv_unified_mem_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .pc                (pc),
        .aluOut            (aluOut),
        .rs2               (rs2),
        .memoryReadEnable  (memoryReadEnable),
        .memoryWriteEnable (memoryWriteEnable),
        .instruction       (instruction),
        .memoryOut         (memoryOut),
        .commit            (commit),
        .misaligned        (misaligned),
        .retired           (retired),
        .mem               (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (obs=running exp=finished)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        pc = 32'h40;
        aluOut = 32'h0;
        rs2 = 32'h0;
        memoryReadEnable = 1'b0;
        memoryWriteEnable = 1'b0;
        bus.memRdata = 32'h0;
        bus.memReady = 1'b1;

        // ---- reset state (memReady high must not matter) ----
        tick(); tick();
        #1;
        chk("rst_memReq",      {31'b0, bus.memReq},      32'h0);
        chk("rst_memWe",       {31'b0, bus.memWe},       32'h0);
        chk("rst_memAddr",     bus.memAddr,              32'h0);
        chk("rst_commit",      {31'b0, commit},          32'h0);
        chk("rst_instruction", instruction,              32'h0000_0013);
        chk("rst_memoryOut",   memoryOut,                32'h0);
        chk("rst_retired",     retired,                  32'h0);
        chk("rst_misaligned",  {31'b0, misaligned},      32'h0);

        // ---- ALU instruction, zero-wait ----
        tick();
        rst = 1'b0;
        pc = 32'h0;
        bus.memRdata = 32'h0050_0093;
        bus.memReady = 1'b1;
        #1;
        chk("alu_f_memReq",  {31'b0, bus.memReq}, 32'h1);
        chk("alu_f_memAddr", bus.memAddr,         32'h0);
        chk("alu_f_memWe",   {31'b0, bus.memWe},  32'h0);
        chk("alu_f_commit",  {31'b0, commit},     32'h0);
        tick();
        bus.memReady = 1'b0;
        #1;
        chk("alu_d_instruction", instruction,         32'h0050_0093);
        chk("alu_d_memReq",      {31'b0, bus.memReq}, 32'h0);
        chk("alu_d_commit",      {31'b0, commit},     32'h1);
        tick();
        pc = 32'h4;
        bus.memRdata = 32'h1000_2083;
        bus.memReady = 1'b1;
        #1;
        chk("alu_retired",     retired,              32'h1);
        chk("ld_f_memReq",     {31'b0, bus.memReq},  32'h1);
        chk("ld_f_memAddr",    bus.memAddr,          32'h4);
        chk("ld_f_commit",     {31'b0, commit},      32'h0);

        // ---- aligned load, 3 wait cycles in DATA ----
        tick();
        memoryReadEnable = 1'b1;
        aluOut = 32'h100;
        bus.memReady = 1'b0;
        bus.memRdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_d_instruction", instruction,         32'h1000_2083);
        chk("ld_d_memReq",      {31'b0, bus.memReq}, 32'h0);
        chk("ld_d_commit",      {31'b0, commit},     32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.memReady = (i == 3);
            #1;
            chk($sformatf("ld_data%0d_memReq", i),  {31'b0, bus.memReq}, 32'h1);
            chk($sformatf("ld_data%0d_memAddr", i), bus.memAddr,         32'h100);
            chk($sformatf("ld_data%0d_memWe", i),   {31'b0, bus.memWe},  32'h0);
            chk($sformatf("ld_data%0d_commit", i),  {31'b0, commit},     32'h0);
        end
        tick();
        bus.memReady = 1'b0;
        #1;
        chk("ld_wb_memoryOut", memoryOut,            32'hDEAD_BEEF);
        chk("ld_wb_commit",    {31'b0, commit},      32'h1);
        chk("ld_wb_memReq",    {31'b0, bus.memReq},  32'h0);
        chk("ld_wb_retired",   retired,              32'h1);

        // ---- aligned store, 1 wait cycle ----
        tick();
        memoryReadEnable = 1'b0;
        pc = 32'h8;
        bus.memRdata = 32'h2020_2223;
        bus.memReady = 1'b1;
        #1;
        chk("ld_retired",   retired,      32'h2);
        chk("st_f_memAddr", bus.memAddr,  32'h8);
        tick();
        memoryWriteEnable = 1'b1;
        aluOut = 32'h204;
        rs2 = 32'h1234_5678;
        bus.memReady = 1'b0;
        #1;
        chk("st_d_memWe",    {31'b0, bus.memWe},  32'h0);
        chk("st_d_memWdata", bus.memWdata,        32'h0);
        chk("st_d_memReq",   {31'b0, bus.memReq}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.memReady = (i == 1);
            bus.memRdata = 32'hCAFE_F00D;
            #1;
            chk($sformatf("st_data%0d_memReq", i),   {31'b0, bus.memReq}, 32'h1);
            chk($sformatf("st_data%0d_memWe", i),    {31'b0, bus.memWe},  32'h1);
            chk($sformatf("st_data%0d_memWdata", i), bus.memWdata,        32'h1234_5678);
            chk($sformatf("st_data%0d_memAddr", i),  bus.memAddr,         32'h204);
        end
        tick();
        bus.memReady = 1'b0;
        #1;
        chk("st_wb_commit",    {31'b0, commit},     32'h1);
        chk("st_wb_memoryOut", memoryOut,           32'hDEAD_BEEF);
        chk("st_wb_memWe",     {31'b0, bus.memWe},  32'h0);

        // ---- misaligned load ----
        tick();
        memoryWriteEnable = 1'b0;
        pc = 32'hC;
        bus.memRdata = 32'h1020_2083;
        bus.memReady = 1'b1;
        #1;
        chk("st_retired", retired, 32'h3);
        tick();
        memoryReadEnable = 1'b1;
        aluOut = 32'h102;
        #1;
        chk("mis_d_memReq", {31'b0, bus.memReq}, 32'h0);
        chk("mis_d_commit", {31'b0, commit},     32'h0);
        tick();
        #1;
        chk("mis_wb_memReq",     {31'b0, bus.memReq},  32'h0);
        chk("mis_wb_misaligned", {31'b0, misaligned},  32'h1);
        chk("mis_wb_memoryOut",  memoryOut,            32'h0);
        chk("mis_wb_commit",     {31'b0, commit},      32'h1);

        // ---- reset during a stalled DATA request ----
        tick();
        memoryReadEnable = 1'b0;
        pc = 32'h10;
        bus.memRdata = 32'h2000_2083;
        bus.memReady = 1'b1;
        #1;
        chk("mis_retired",    retired,             32'h4);
        chk("mis_sticky",     {31'b0, misaligned}, 32'h1);
        tick();
        memoryReadEnable = 1'b1;
        aluOut = 32'h200;
        bus.memReady = 1'b0;
        tick();
        #1;
        chk("rr_data_memReq",  {31'b0, bus.memReq}, 32'h1);
        chk("rr_data_memAddr", bus.memAddr,         32'h200);
        #1;
        rst = 1'b1;
        #1;
        chk("rr_memReq",      {31'b0, bus.memReq},  32'h0);
        chk("rr_memAddr",     bus.memAddr,          32'h0);
        chk("rr_retired",     retired,              32'h0);
        chk("rr_instruction", instruction,          32'h0000_0013);
        chk("rr_memoryOut",   memoryOut,            32'h0);
        chk("rr_misaligned",  {31'b0, misaligned},  32'h0);
        chk("rr_commit",      {31'b0, commit},      32'h0);
        tick();
        rst = 1'b0;
        memoryReadEnable = 1'b0;
        bus.memRdata = 32'h0000_0013;
        bus.memReady = 1'b1;
        #1;
        chk("rr_refetch_memReq",  {31'b0, bus.memReq}, 32'h1);
        chk("rr_refetch_memAddr", bus.memAddr,         32'h10);

        // ---- retired wrap ----
        tick();
        bus.memReady = 1'b0;
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        #1;
        chk("wrap_pre_retired", retired,         32'hFFFF_FFFF);
        chk("wrap_commit",      {31'b0, commit}, 32'h1);
        tick();
        #1;
        chk("wrap_retired", retired,             32'h0);
        chk("wrap_memReq",  {31'b0, bus.memReq}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
